// File: rtl/legv8_pkg.sv
// Shared definitions for the LEGv8 front end: fetch FSM states, the
// architectural widths and the fetch-buffer entry layout used by decode.
package legv8_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;

    // Fetch sequencer states: idle, request on the bus, waiting for data,
    // and draining a response that belongs to a flushed fetch.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_e;

    // One buffered instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/legv8_fetch_fifo.sv
// Small first-word-fall-through circular buffer with a synchronous clear.
// Written generically (DEPTH entries of WIDTH bits) so later stage buffers
// can reuse it. Pushing while full is not guarded; the producer guarantees
// it never happens.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o,
    output logic             full_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             do_push;
    logic             do_pop;

    // Clear wins over both push and pop in the same cycle.
    assign do_push = push_i && !clear_i;
    assign do_pop  = pop_i && valid_o && !clear_i;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == FULL_CNT);

    // Head entry is visible combinationally; an empty buffer presents zero
    // so the outputs have a defined value straight out of reset.
    assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;

    // Next occupancy: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        // NOTE: default assignment first so no path through the block can infer a latch.
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Entry storage is written on push only.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; valid_o (from count_q) qualifies every read.
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/legv8_fetch_unit.sv
// Instruction-fetch stage: captures the PC, issues one word-aligned memory
// read at a time over a request/grant handshake, and buffers the returned
// instruction with its PC toward decode. A branch redirect (flush) abandons
// the in-flight fetch and empties the buffer; a response that still arrives
// for an abandoned fetch is swallowed in DROP.
module legv8_fetch_unit #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_advance,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              busy
);

    import legv8_pkg::*;

    localparam int ENTRY_W = ADDR_W + DATA_W;

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic              imem_req_q;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_valid;
    logic              fifo_full;
    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic [ADDR_W-1:0] aligned_pc;
    logic              unused_pc_low;

    // Instructions are word aligned; the two low PC bits never reach memory.
    assign aligned_pc    = {pc_addr[ADDR_W-1:2], 2'b00};
    assign unused_pc_low = ^pc_addr[1:0];

    // The PC is consumed in the same cycle the fetch is launched, so the
    // upstream counter can step without waiting for the grant. Only one
    // fetch is ever outstanding, so "not full" is enough room for it.
    assign pc_advance = (state_q == ST_IDLE) && !flush && !fifo_full && !reset;

    // Data is kept only when it returns for a live fetch in a non-flush cycle.
    assign fifo_push  = (state_q == ST_WAIT) && imem_rvalid && !flush;
    assign fifo_pop   = fifo_valid && if_ready;
    assign fifo_wdata = {req_addr_q, imem_rdata};

    assign imem_req  = imem_req_q;
    assign imem_addr = req_addr_q;

    assign if_valid = fifo_valid;
    assign if_pc    = fifo_rdata[DATA_W +: ADDR_W];
    assign if_instr = fifo_rdata[DATA_W-1:0];
    assign busy     = (state_q != ST_IDLE) || fifo_valid;

    // Fetch sequencer with registered request and address outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            req_addr_q <= '0;
            imem_req_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pc_advance) begin
                        req_addr_q <= aligned_pc;
                        imem_req_q <= 1'b1;
                        state_q    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Address is held until grant; withdrawal is only legal on flush.
                    if (imem_gnt) begin
                        imem_req_q <= 1'b0;
                        state_q    <= flush ? ST_DROP : ST_WAIT;
                    end else if (flush) begin
                        imem_req_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    // A flush before data arrives still owes us one response.
                    if (imem_rvalid) begin
                        state_q <= ST_IDLE;
                    end else if (flush) begin
                        state_q <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (imem_rvalid) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear_i (flush),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .valid_o (fifo_valid),
        .full_o  (fifo_full)
    );

endmodule

// File: tb/tb_legv8_fetch_unit.sv
// Self-checking bench for legv8_fetch_unit: a transaction-level model of
// the fetch stage (outstanding-fetch bookkeeping plus a queue of buffered
// instructions) is compared against the DUT every cycle, with directed
// scenarios pinned by literal expectations and a long randomized run.
module tb_legv8_fetch_unit;

    import legv8_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_addr;
    logic        pc_advance;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        busy;

    always #5 clk = ~clk;

    legv8_fetch_unit #(
        .DEPTH  (DEPTH),
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_addr     (pc_addr),
        .pc_advance  (pc_advance),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .busy        (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 = nothing outstanding, 1 = address offered, 2 = awaiting data
    fetch_entry_t mq[$];
    int           m_phase  = 0;
    bit           m_killed = 1'b0;
    logic [31:0]  m_addr   = '0;
    bit           m_known  = 1'b0;

    // ---------------- memory responder / upstream ----------------
    int          rsp_cnt     = -1;
    int          gnt_wait    = 0;
    int          gnt_delay   = 0;
    int          rsp_delay   = 1;
    bit          rand_delays = 1'b0;
    logic [31:0] rsp_addr    = '0;
    bit          override_en = 1'b0;
    logic [31:0] override_data = '0;
    bit          stray_rvalid = 1'b0;
    bit          auto_pc      = 1'b1;

    // Values seen in the last cycle, for the directed literal checks.
    logic        s_adv, s_req, s_valid, s_busy;
    logic [31:0] s_addr, s_pc, s_instr;
    logic [31:0] popped[$];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic drive_mem();
        imem_gnt    = (imem_req === 1'b1) && (gnt_wait >= gnt_delay);
        imem_rvalid = (rsp_cnt == 0) || stray_rvalid;
        if (imem_rvalid)
            imem_rdata = override_en ? override_data : mem_data(rsp_addr);
        else
            imem_rdata = $urandom();
    endtask

    // One clock: compare at the falling edge, advance model and responder,
    // then return just after the next rising edge with inputs unchanged.
    task automatic step();
        bit           exp_adv;
        bit           push;
        fetch_entry_t e;
        @(negedge clk);
        s_adv = pc_advance; s_req = imem_req; s_valid = if_valid; s_busy = busy;
        s_addr = imem_addr; s_pc = if_pc; s_instr = if_instr;
        exp_adv = !reset && (m_phase == 0) && !flush && (mq.size() < DEPTH);
        if (m_known) begin
            check("pc_advance", {31'd0, pc_advance}, {31'd0, exp_adv});
            check("imem_req", {31'd0, imem_req}, {31'd0, m_phase == 1});
            if (m_phase == 1) check("imem_addr", imem_addr, m_addr);
            check("if_valid", {31'd0, if_valid}, {31'd0, mq.size() > 0});
            if (mq.size() > 0) begin
                check("if_pc", if_pc, mq[0].pc);
                check("if_instr", if_instr, mq[0].instr);
            end
            check("busy", {31'd0, busy}, {31'd0, (m_phase != 0) || (mq.size() > 0)});
        end
        if (!reset && !flush && if_valid === 1'b1 && if_ready) popped.push_back(if_pc);
        // model update
        if (reset) begin
            m_phase = 0; m_killed = 1'b0; m_addr = '0; mq.delete(); m_known = 1'b1;
        end else if (m_known) begin
            push = 1'b0;
            e    = '0;
            case (m_phase)
                0: if (exp_adv) begin m_phase = 1; m_addr = {pc_addr[31:2], 2'b00}; end
                1: begin
                    if (imem_gnt) begin m_phase = 2; m_killed = flush; end
                    else if (flush) m_phase = 0;
                end
                default: begin
                    if (imem_rvalid) begin
                        if (!m_killed && !flush) begin push = 1'b1; e.pc = m_addr; e.instr = imem_rdata; end
                        m_phase = 0;
                    end else if (flush) m_killed = 1'b1;
                end
            endcase
            if (flush) mq.delete();
            else begin
                if (mq.size() > 0 && if_ready) void'(mq.pop_front());
                if (push) mq.push_back(e);
            end
        end
        // responder update
        if (reset) begin
            rsp_cnt = -1; gnt_wait = 0;
        end else begin
            if (imem_rvalid && rsp_cnt == 0) rsp_cnt = -1;
            else if (rsp_cnt > 0) rsp_cnt--;
            if (imem_gnt) begin
                rsp_cnt  = rsp_delay - 1;
                rsp_addr = imem_addr;
                gnt_wait = 0;
                if (rand_delays) begin
                    gnt_delay = $urandom_range(0, 3);
                    rsp_delay = $urandom_range(1, 3);
                end
            end else if (imem_req === 1'b1) gnt_wait++;
            else gnt_wait = 0;
        end
        @(posedge clk);
        #1;
        if (auto_pc && s_adv === 1'b1) pc_addr = pc_addr + 32'd4;
    endtask

    task automatic cycle();
        drive_mem();
        step();
    endtask

    task automatic do_reset(input logic [31:0] start_pc);
        reset = 1'b1; flush = 1'b0; if_ready = 1'b0; pc_addr = start_pc;
        gnt_delay = 0; rsp_delay = 1; rand_delays = 1'b0;
        override_en = 1'b0; stray_rvalid = 1'b0; auto_pc = 1'b1;
        cycle();
        cycle();
        check("rst_imem_addr", s_addr, 32'h0);
        check("rst_if_instr", s_instr, 32'h0);
        check("rst_if_pc", s_pc, 32'h0);
        check("rst_pc_advance", {31'd0, s_adv}, 32'd0);
        check("rst_busy", {31'd0, s_busy}, 32'd0);
        reset = 1'b0;
        popped.delete();
    endtask

    int  n_adv;
    int  n_req;
    bit  saw_dropped;

    initial begin
        reset = 1'b1; flush = 1'b0; if_ready = 1'b0; pc_addr = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

        // 1: single fetch, 1-cycle memory
        do_reset(32'h0);
        override_en = 1'b1; override_data = 32'h8B02_0020;
        cycle(); check("t1_adv_c1", {31'd0, s_adv}, 32'd1);
        cycle(); cycle(); cycle();
        check("t1_valid_c4", {31'd0, s_valid}, 32'd1);
        check("t1_pc_c4", s_pc, 32'h0);
        check("t1_instr_c4", s_instr, 32'h8B02_0020);
        override_en = 1'b0;

        // 2: decode stalled, buffer fills at two entries, then drains in order
        do_reset(32'h0);
        n_adv = 0; n_req = 0;
        for (int i = 0; i < 15; i++) begin
            cycle();
            n_adv += int'(s_adv);
            if (i >= 7) n_req += int'(s_req);
        end
        check("t2_adv_count", n_adv, 2);
        check("t2_req_stalled", n_req, 0);
        check("t2_valid_full", {31'd0, s_valid}, 32'd1);
        if_ready = 1'b1;
        for (int i = 0; i < 12; i++) cycle();
        check("t2_pop_count_ge3", {31'd0, popped.size() >= 3}, 32'd1);
        if (popped.size() >= 3) begin
            check("t2_pop0", popped[0], 32'h0);
            check("t2_pop1", popped[1], 32'h4);
            check("t2_pop2", popped[2], 32'h8);
        end

        // 3: flush while waiting for data, late response dropped
        do_reset(32'h10);
        rsp_delay = 3; if_ready = 1'b1;
        cycle(); cycle();
        flush = 1'b1; pc_addr = 32'h40;
        cycle();
        flush = 1'b0;
        saw_dropped = 1'b0;
        cycle(); saw_dropped |= (s_valid === 1'b1);
        cycle(); saw_dropped |= (s_valid === 1'b1);
        cycle(); check("t3_adv_after_drop", {31'd0, s_adv}, 32'd1);
        cycle();
        check("t3_req", {31'd0, s_req}, 32'd1);
        check("t3_redirect_addr", s_addr, 32'h40);
        for (int i = 0; i < 8; i++) cycle();
        check("t3_no_stale_valid", {31'd0, saw_dropped}, 32'd0);
        check("t3_first_pop", (popped.size() > 0) ? popped[0] : 32'hFFFF_FFFF, 32'h40);

        // 4: flush while full with decode ready in the same cycle
        do_reset(32'h100);
        for (int i = 0; i < 10; i++) cycle();
        check("t4_full_valid", {31'd0, s_valid}, 32'd1);
        if_ready = 1'b1; flush = 1'b1; pc_addr = 32'h200;
        cycle();
        flush = 1'b0; if_ready = 1'b0;
        cycle();
        check("t4_valid_cleared", {31'd0, s_valid}, 32'd0);
        check("t4_no_pop", popped.size(), 0);
        check("t4_adv_after_clear", {31'd0, s_adv}, 32'd1);
        cycle();
        check("t4_redirect_addr", s_addr, 32'h200);

        // 5: grant held off three cycles, unaligned PC
        do_reset(32'h22);
        gnt_delay = 3;
        n_adv = 0;
        cycle(); n_adv += int'(s_adv);
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_adv += int'(s_adv);
            check("t5_req_held", {31'd0, s_req}, 32'd1);
            check("t5_addr_stable", s_addr, 32'h20);
        end
        check("t5_single_adv", n_adv, 1);
        for (int i = 0; i < 4; i++) cycle();

        // 6: reset in WAIT, stray response right after release
        do_reset(32'h0);
        rsp_delay = 3;
        cycle(); cycle();
        reset = 1'b1;
        cycle(); cycle();
        reset = 1'b0; stray_rvalid = 1'b1; override_en = 1'b1; override_data = 32'hDEAD_BEEF;
        cycle();
        check("t6_idle", {31'd0, s_busy}, 32'd0);
        check("t6_valid_c5", {31'd0, s_valid}, 32'd0);
        stray_rvalid = 1'b0; override_en = 1'b0;
        cycle();
        check("t6_valid_c6", {31'd0, s_valid}, 32'd0);
        check("t6_new_req", {31'd0, s_req}, 32'd1);
        for (int i = 0; i < 6; i++) cycle();

        // randomized traffic
        do_reset($urandom());
        rand_delays = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if_ready = ($urandom_range(0, 9) < 7);
            flush    = ($urandom_range(0, 19) == 0);
            if (flush) pc_addr = $urandom();
            cycle();
        end
        flush = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/legv8_fetch_unit.md
Name: legv8_fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the 32-bit program counter.
- Takes the current PC address and issues one instruction-memory read at a time, with a request/grant handshake and an in-order response.
- Buffers returned instructions, each with its PC, in a small FIFO toward decode, using a valid/ready handshake.
- Tells the next-PC logic when an address has been consumed; supports flush on branch redirect.

Parameters:
DEPTH, 2, number of entries in the fetch FIFO (power of two, ≥2)
ADDR_W, 32, width of PC and memory address
DATA_W, 32, instruction width

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
pc_addr  input  ADDR_W  current PC value from program counter
pc_advance  output  1  one-cycle pulse: pc_addr captured, upstream may step PC
flush  input  1  branch redirect: discard in-flight fetch and FIFO contents
imem_req  output  1  memory read request
imem_addr  output  ADDR_W  request address, word aligned
imem_gnt  input  1  memory accepts request this cycle
imem_rvalid  input  1  read data valid (in order, ≥1 cycle after gnt)
imem_rdata  input  DATA_W  read data
if_valid  output  1  FIFO head valid toward decode
if_ready  input  1  decode accepts head
if_instr  output  DATA_W  head instruction
if_pc  output  ADDR_W  head PC
busy  output  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset: state IDLE, FIFO empty, count 0. Reset values: imem_req, pc_advance, if_valid, busy = 0; imem_addr, if_instr, if_pc = 0.
- Reset mid-fetch: abandons the fetch. A stray rvalid after reset is ignored, because rvalid is sampled only in WAIT and DROP.
- Registered FSM, states IDLE, REQ, WAIT, DROP.
- IDLE:
  - If !flush and count < DEPTH: req_addr <= {pc_addr[ADDR_W-1:2],2'b00}, pc_advance = 1 this cycle (combinational), next state REQ.
  - Otherwise stay in IDLE; pc_advance = 0.
- REQ:
  - imem_req = 1, imem_addr = req_addr.
  - gnt & !flush -> WAIT.
  - gnt & flush -> DROP.
  - !gnt & flush -> IDLE; the request is withdrawn, which is allowed only on flush.
  - Otherwise stay in REQ; imem_addr is held stable.
- WAIT:
  - rvalid & !flush -> push {req_addr, imem_rdata}, then IDLE.
  - rvalid & flush -> discard, then IDLE.
  - !rvalid & flush -> DROP.
- DROP: on rvalid, discard the data, then IDLE. flush in DROP has no further effect.
- Peak throughput is 1 instruction per 3 cycles with a 1-cycle memory; no request pipelining.
- FIFO:
  - Circular buffer with wr_ptr/rd_ptr of log2(DEPTH) bits wrapping modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
  - Pop when if_valid & if_ready. if_valid = (count != 0); if_instr/if_pc come from the head entry, first-word-fall-through.
  - Simultaneous push and pop leaves count unchanged. Push never occurs when full, since an issue requires count < DEPTH in IDLE and at most one fetch is outstanding.
- Flush priority: flush overrides push and pop in the same cycle. FIFO is cleared (pointers and count = 0), so if_valid = 0 from the next cycle. No pc_advance in a flush cycle.
- Upstream PC must hold pc_addr stable until pc_advance. After flush, upstream presents the redirect target on pc_addr.

Decomposition:
- Shared package legv8_pkg holds:
  - fetch state enum (IDLE, REQ, WAIT, DROP)
  - INSTR_W = 32, ADDR_W = 32
  - typedef fetch_entry_t {pc, instr}
- Sub-module fetch_fifo (parameterised DEPTH, entry width, synchronous clear) is natural and reusable for later stage buffers.

Test Plan:
- Reset, then pc_addr = 0x00000000, gnt same cycle, rvalid 1 cycle later with rdata 0x8B020020 -> pc_advance pulses cycle 1; if_valid with if_pc = 0x0, if_instr = 0x8B020020 four cycles after reset release.
- if_ready = 0; fetch PCs 0x0, 0x4, 0x8 -> FIFO holds 2 entries; no third pc_advance and imem_req stays 0 until decode pops; then 0x8 is fetched; output order is 0x0, 0x4, 0x8.
- flush asserted in WAIT for PC 0x10, rvalid two cycles later -> data dropped, never seen on if_instr; next fetch uses redirect pc_addr = 0x40.
- flush with FIFO full and if_ready = 1 in the same cycle -> if_valid = 0 next cycle, count = 0, no pop recorded by decode.
- gnt delayed 3 cycles in REQ -> imem_addr stable at 0x20 throughout, single pc_advance; pc_addr = 0x22 is fetched as imem_addr 0x20.
- reset asserted in WAIT, rvalid arrives the cycle after reset release -> ignored; if_valid stays 0; FSM in IDLE.
